// File: rtl/lifo_stack.sv
// Parametrised LIFO operand stack with push, pop, swap, overwrite-top and collapse.
// Optional macro LIFO_STACK_PEEK_EN adds PEEK_DAT/PEEK_VLD (second entry from the top).
module lifo_stack #(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CLR,
    input  logic          PUSH_STB,
    input  logic [DW-1:0] PUSH_DAT,
    input  logic          OW,
    output logic          PUSH_ACK,
    output logic          POP_STB,
    output logic [DW-1:0] POP_DAT,
    input  logic          POP_ACK,
    output logic [AW:0]   COUNT,
    output logic          FULL,
    output logic          EMPTY,
`ifdef LIFO_STACK_PEEK_EN
    output logic [DW-1:0] PEEK_DAT,
    output logic          PEEK_VLD,
`endif
    output logic          ERR
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] TWO   = ONE + ONE;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW:0]   count_q, count_d;
    logic [DW-1:0] top_q, top_d;
    logic          err_q;

    logic          empty, full, count_ge2, pop_fire, push_ack;
    logic [AW:0]   idx_m1, idx_m2;
    logic [DW-1:0] below_top;
    logic          we;
    logic [AW-1:0] waddr;

    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH);
    assign count_ge2 = (count_q >= TWO);
    assign pop_fire  = POP_ACK & ~empty;
    assign idx_m1    = count_q - ONE;
    assign idx_m2    = count_q - TWO;
    assign below_top = mem[idx_m2[AW-1:0]];

    // Overwrite/collapse need an existing top; a collapse needs two entries.
    assign push_ack = PUSH_STB & (OW ? (pop_fire ? count_ge2 : ~empty)
                                     : (~full | pop_fire));

    always_comb begin
        count_d = count_q;
        top_d   = top_q;
        we      = 1'b0;
        waddr   = count_q[AW-1:0];
        if (CLR) begin
            count_d = '0;
            top_d   = '0;
        end else begin
            case ({push_ack, OW, pop_fire})
                3'b100: begin
                    we      = 1'b1;
                    waddr   = count_q[AW-1:0];
                    count_d = count_q + ONE;
                    top_d   = PUSH_DAT;
                end
                3'b101, 3'b110: begin
                    we    = 1'b1;
                    waddr = idx_m1[AW-1:0];
                    top_d = PUSH_DAT;
                end
                3'b111: begin
                    we      = 1'b1;
                    waddr   = idx_m2[AW-1:0];
                    count_d = count_q - ONE;
                    top_d   = PUSH_DAT;
                end
                3'b001, 3'b011: begin
                    count_d = count_q - ONE;
                    top_d   = (count_q == ONE) ? '0 : below_top;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q <= '0;
            top_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            top_q   <= top_d;
            if (!CLR && POP_ACK && empty)
                err_q <= 1'b1;
        end
    end

    // Storage is deliberately not reset; only entries below COUNT are ever read.
    always_ff @(posedge CLK) begin
        if (we)
            mem[waddr] <= PUSH_DAT;
    end

    assign PUSH_ACK = push_ack;
    assign POP_STB  = ~empty;
    assign POP_DAT  = top_q;
    assign COUNT    = count_q;
    assign FULL     = full;
    assign EMPTY    = empty;
    assign ERR      = err_q;

`ifdef LIFO_STACK_PEEK_EN
    assign PEEK_VLD = count_ge2;
    assign PEEK_DAT = count_ge2 ? below_top : '0;
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// Directed self-checking bench for lifo_stack (AW=2, depth 4).
module tb_lifo_stack;

    localparam int DW = 32;
    localparam int AW = 2;

    logic          CLK = 1'b0;
    logic          RST, CLR, PUSH_STB, OW, POP_ACK;
    logic [DW-1:0] PUSH_DAT;
    logic          PUSH_ACK, POP_STB, FULL, EMPTY, ERR;
    logic [DW-1:0] POP_DAT;
    logic [AW:0]   COUNT;
`ifdef LIFO_STACK_PEEK_EN
    logic [DW-1:0] PEEK_DAT;
    logic          PEEK_VLD;
`endif

    int checks = 0;
    int errors = 0;

    lifo_stack #(.DW(DW), .AW(AW)) dut (
        .CLK(CLK), .RST(RST), .CLR(CLR),
        .PUSH_STB(PUSH_STB), .PUSH_DAT(PUSH_DAT), .OW(OW), .PUSH_ACK(PUSH_ACK),
        .POP_STB(POP_STB), .POP_DAT(POP_DAT), .POP_ACK(POP_ACK),
        .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY),
`ifdef LIFO_STACK_PEEK_EN
        .PEEK_DAT(PEEK_DAT), .PEEK_VLD(PEEK_VLD),
`endif
        .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        CLR = 0; PUSH_STB = 0; OW = 0; POP_ACK = 0; PUSH_DAT = '0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        idle_inputs();
        #2;
        checks++; if (COUNT !== 3'd0)   begin errors++; $display("[TB] FAIL reset_count: got %0d want 0", COUNT); end
        checks++; if (POP_DAT !== 32'd0) begin errors++; $display("[TB] FAIL reset_pop_dat: got %0h want 0", POP_DAT); end
        checks++; if (POP_STB !== 1'b0) begin errors++; $display("[TB] FAIL reset_pop_stb: got %b want 0", POP_STB); end
        checks++; if (EMPTY !== 1'b1)   begin errors++; $display("[TB] FAIL reset_empty: got %b want 1", EMPTY); end
        checks++; if (FULL !== 1'b0)    begin errors++; $display("[TB] FAIL reset_full: got %b want 0", FULL); end
        checks++; if (ERR !== 1'b0)     begin errors++; $display("[TB] FAIL reset_err: got %b want 0", ERR); end
        checks++; if (PUSH_ACK !== 1'b0) begin errors++; $display("[TB] FAIL reset_push_ack: got %b want 0", PUSH_ACK); end
        @(negedge CLK);
        RST = 1'b0;
        tick();
    endtask

    task automatic test_push_pop();
        logic [DW-1:0] exp_dat [3] = '{32'd2, 32'd1, 32'd0};
        for (int i = 1; i <= 3; i++) begin
            PUSH_STB = 1; PUSH_DAT = i;
            #1;
            checks++; if (PUSH_ACK !== 1'b1) begin errors++; $display("[TB] FAIL push_ack_%0d: got %b want 1", i, PUSH_ACK); end
            tick();
            checks++; if (POP_DAT !== DW'(i) || COUNT !== 3'(i)) begin errors++; $display("[TB] FAIL push_%0d: got dat %0h cnt %0d want dat %0h cnt %0d", i, POP_DAT, COUNT, i, i); end
        end
        PUSH_STB = 0; POP_ACK = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (POP_DAT !== exp_dat[i] || COUNT !== 3'(2 - i)) begin errors++; $display("[TB] FAIL pop_%0d: got dat %0h cnt %0d want dat %0h cnt %0d", i, POP_DAT, COUNT, exp_dat[i], 2 - i); end
        end
        POP_ACK = 0;
        checks++; if (EMPTY !== 1'b1 || ERR !== 1'b0 || POP_STB !== 1'b0) begin errors++; $display("[TB] FAIL pop_end: got empty %b err %b stb %b want 1 0 0", EMPTY, ERR, POP_STB); end
    endtask

    task automatic test_full_swap();
        for (int i = 0; i < 4; i++) begin
            PUSH_STB = 1; PUSH_DAT = 32'd10 + i;
            tick();
        end
        checks++; if (COUNT !== 3'd4 || FULL !== 1'b1) begin errors++; $display("[TB] FAIL fill: got cnt %0d full %b want 4 1", COUNT, FULL); end
        PUSH_DAT = 32'd14;
        #1;
        checks++; if (PUSH_ACK !== 1'b0) begin errors++; $display("[TB] FAIL full_refuse_ack: got %b want 0", PUSH_ACK); end
        tick();
        checks++; if (COUNT !== 3'd4 || POP_DAT !== 32'd13) begin errors++; $display("[TB] FAIL full_refuse_state: got cnt %0d dat %0h want 4 d", COUNT, POP_DAT); end
        PUSH_DAT = 32'd9; POP_ACK = 1;
        #1;
        checks++; if (PUSH_ACK !== 1'b1) begin errors++; $display("[TB] FAIL swap_ack: got %b want 1", PUSH_ACK); end
        tick();
        checks++; if (POP_DAT !== 32'd9 || COUNT !== 3'd4 || FULL !== 1'b1) begin errors++; $display("[TB] FAIL swap: got dat %0h cnt %0d full %b want 9 4 1", POP_DAT, COUNT, FULL); end
        PUSH_STB = 0;
        tick();
        checks++; if (POP_DAT !== 32'd12 || COUNT !== 3'd3) begin errors++; $display("[TB] FAIL pop_after_swap: got dat %0h cnt %0d want c 3", POP_DAT, COUNT); end
        POP_ACK = 0; CLR = 1;
        tick();
        CLR = 0;
        checks++; if (COUNT !== 3'd0 || POP_DAT !== 32'd0) begin errors++; $display("[TB] FAIL clear_after_full: got cnt %0d dat %0h want 0 0", COUNT, POP_DAT); end
    endtask

    task automatic test_collapse();
        PUSH_STB = 1; PUSH_DAT = 32'd7; tick();
        PUSH_DAT = 32'd8; tick();
        OW = 1; POP_ACK = 1; PUSH_DAT = 32'd15;
        #1;
`ifdef LIFO_STACK_PEEK_EN
        checks++; if (PEEK_VLD !== 1'b1 || PEEK_DAT !== 32'd7) begin errors++; $display("[TB] FAIL peek: got vld %b dat %0h want 1 7", PEEK_VLD, PEEK_DAT); end
`endif
        checks++; if (PUSH_ACK !== 1'b1) begin errors++; $display("[TB] FAIL collapse_ack: got %b want 1", PUSH_ACK); end
        tick();
        checks++; if (COUNT !== 3'd1 || POP_DAT !== 32'd15) begin errors++; $display("[TB] FAIL collapse: got cnt %0d dat %0h want 1 f", COUNT, POP_DAT); end
        PUSH_DAT = 32'd20;
        #1;
        checks++; if (PUSH_ACK !== 1'b0) begin errors++; $display("[TB] FAIL collapse_one_ack: got %b want 0", PUSH_ACK); end
        tick();
        idle_inputs();
        checks++; if (COUNT !== 3'd0 || POP_DAT !== 32'd0 || ERR !== 1'b0) begin errors++; $display("[TB] FAIL collapse_one: got cnt %0d dat %0h err %b want 0 0 0", COUNT, POP_DAT, ERR); end
    endtask

    task automatic test_underflow();
        POP_ACK = 1;
        tick();
        POP_ACK = 0;
        checks++; if (ERR !== 1'b1 || COUNT !== 3'd0) begin errors++; $display("[TB] FAIL underflow: got err %b cnt %0d want 1 0", ERR, COUNT); end
        PUSH_STB = 1; OW = 1; PUSH_DAT = 32'd3;
        #1;
        checks++; if (PUSH_ACK !== 1'b0) begin errors++; $display("[TB] FAIL ow_empty_ack: got %b want 0", PUSH_ACK); end
        tick();
        idle_inputs();
        tick();
        checks++; if (ERR !== 1'b1 || COUNT !== 3'd0) begin errors++; $display("[TB] FAIL err_sticky: got err %b cnt %0d want 1 0", ERR, COUNT); end
    endtask

    task automatic test_overwrite_clear();
        PUSH_STB = 1; PUSH_DAT = 32'd4; tick();
        OW = 1; PUSH_DAT = 32'd6;
        #1;
        checks++; if (PUSH_ACK !== 1'b1) begin errors++; $display("[TB] FAIL overwrite_ack: got %b want 1", PUSH_ACK); end
        tick();
        checks++; if (COUNT !== 3'd1 || POP_DAT !== 32'd6) begin errors++; $display("[TB] FAIL overwrite: got cnt %0d dat %0h want 1 6", COUNT, POP_DAT); end
        OW = 0; CLR = 1; PUSH_DAT = 32'd99;
        tick();
        idle_inputs();
        checks++; if (COUNT !== 3'd0 || POP_DAT !== 32'd0 || ERR !== 1'b1) begin errors++; $display("[TB] FAIL clr_with_push: got cnt %0d dat %0h err %b want 0 0 1", COUNT, POP_DAT, ERR); end
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 3; i++) begin
            PUSH_STB = 1; PUSH_DAT = i; tick();
        end
        PUSH_STB = 0;
        checks++; if (COUNT !== 3'd3) begin errors++; $display("[TB] FAIL pre_reset_count: got %0d want 3", COUNT); end
        #1 RST = 1;
        #1;
        checks++; if (COUNT !== 3'd0 || POP_DAT !== 32'd0 || POP_STB !== 1'b0 || EMPTY !== 1'b1 || FULL !== 1'b0 || ERR !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset: got cnt %0d dat %0h stb %b empty %b full %b err %b want 0 0 0 1 0 0", COUNT, POP_DAT, POP_STB, EMPTY, FULL, ERR); end
        #1 RST = 0;
        PUSH_STB = 1; PUSH_DAT = 32'hA;
        tick();
        idle_inputs();
        checks++; if (POP_DAT !== 32'hA || COUNT !== 3'd1) begin errors++; $display("[TB] FAIL push_after_reset: got dat %0h cnt %0d want a 1", POP_DAT, COUNT); end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_full_swap();
        test_collapse();
        test_underflow();
        test_overwrite_clear();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
